// File: rtl/image_ram_loader.sv
// Loads one RGB332 image from a framed UART byte stream into the image Block RAM write port.
// Optional trailing checksum byte enabled by defining IMAGE_LOADER_CHECKSUM_EN.
module image_ram_loader #(
    parameter int         BusSize        = 11,
    parameter int         NumElements    = 1600,
    parameter int         DataSize       = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_rx_dv,
    input  logic [7:0]          i_rx_byte,
    output logic                o_write_en,
    output logic [BusSize-1:0]  o_write_addr,
    output logic [DataSize-1:0] o_write_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    // state | meaning
    // IDLE  | waiting for SYNC_BYTE, every other byte dropped
    // DATA  | payload bytes written to RAM at consecutive addresses
    // CHECK | waiting for the checksum byte (checksum build only)

    localparam int TimerWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [BusSize-1:0]    LastAddr = BusSize'(NumElements - 1);
    localparam logic [TimerWidth-1:0] TimerEnd = TimerWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA
`ifdef IMAGE_LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t                state;
    logic [BusSize-1:0]    byte_count;
    logic [7:0]            checksum;
    logic [TimerWidth-1:0] idle_timer;

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state        <= IDLE;
            byte_count   <= '0;
            checksum     <= '0;
            idle_timer   <= '0;
            o_write_en   <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_write_en <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    idle_timer <= '0;
                    if (i_rx_dv && i_rx_byte == SYNC_BYTE) begin
                        state      <= DATA;
                        byte_count <= '0;
                        checksum   <= '0;
                        o_error    <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end

                DATA: begin
                    if (i_rx_dv) begin
                        idle_timer   <= '0;
                        o_write_en   <= 1'b1;
                        o_write_addr <= byte_count;
                        o_write_data <= DataSize'(i_rx_byte);
                        checksum     <= checksum + i_rx_byte;
                        if (byte_count == LastAddr) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                            state  <= CHECK;
`else
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
`endif
                        end else begin
                            byte_count <= byte_count + BusSize'(1);
                        end
                    end else if (idle_timer == TimerEnd) begin
                        state      <= IDLE;
                        idle_timer <= '0;
                        o_busy     <= 1'b0;
                        o_error    <= 1'b1;
                    end else begin
                        idle_timer <= idle_timer + TimerWidth'(1);
                    end
                end

`ifdef IMAGE_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (i_rx_dv) begin
                        state      <= IDLE;
                        idle_timer <= '0;
                        o_busy     <= 1'b0;
                        if (i_rx_byte == checksum) o_done  <= 1'b1;
                        else                       o_error <= 1'b1;
                    end else if (idle_timer == TimerEnd) begin
                        state      <= IDLE;
                        idle_timer <= '0;
                        o_busy     <= 1'b0;
                        o_error    <= 1'b1;
                    end else begin
                        idle_timer <= idle_timer + TimerWidth'(1);
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_ram_loader.sv
// Bench for image_ram_loader: directed frames with literal expectations plus a randomized
// byte stream checked every cycle against a count-based frame model.
module tb_image_ram_loader;

    localparam int BUS = 11;
    localparam int NE  = 4;
    localparam int TO  = 16;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx_dv = 1'b0;
    logic [7:0]     rx_byte = 8'h00;
    logic           we, busy, done, err;
    logic [BUS-1:0] waddr;
    logic [7:0]     wdata;

    int checks = 0;
    int errors = 0;

    image_ram_loader #(
        .BusSize(BUS), .NumElements(NE), .DataSize(8),
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK(clk), .i_reset(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .o_write_en(we), .o_write_addr(waddr), .o_write_data(wdata),
        .o_busy(busy), .o_done(done), .o_error(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: tracks how many payload bytes were seen and how long the line has been quiet.
    bit       m_in_frame = 0;
    int       m_n = 0;
    int       m_sum = 0;
    int       m_idle = 0;
    bit       e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
    int       e_addr = 0, e_data = 0;

    always @(posedge clk) begin
        logic s_rst, s_dv;
        logic [7:0] s_b;
        s_rst = rst; s_dv = rx_dv; s_b = rx_byte;
        #1;
        e_we = 0; e_done = 0;
        if (s_rst) begin
            m_in_frame = 0; m_n = 0; m_sum = 0; m_idle = 0;
            e_busy = 0; e_err = 0; e_addr = 0; e_data = 0;
        end else if (!m_in_frame) begin
            if (s_dv && s_b == 8'hA5) begin
                m_in_frame = 1; m_n = 0; m_sum = 0; m_idle = 0;
                e_err = 0; e_busy = 1;
            end
        end else if (s_dv) begin
            m_idle = 0;
            if (m_n < NE) begin
                e_we = 1; e_addr = m_n; e_data = s_b;
                m_sum = (m_sum + s_b) % 256;
                m_n++;
                if (m_n == NE && !CHK) begin
                    e_done = 1; e_busy = 0; m_in_frame = 0;
                end
            end else begin
                if (s_b == m_sum) e_done = 1;
                else              e_err = 1;
                e_busy = 0; m_in_frame = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e_err = 1; e_busy = 0; m_in_frame = 0; m_idle = 0;
            end
        end
        chk("write_en", 32'(we), 32'(e_we));
        chk("write_addr", 32'(waddr), 32'(e_addr));
        chk("write_data", 32'(wdata), 32'(e_data));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(err), 32'(e_err));
    end

    // RAM mirror and pulse counters fed from the DUT write port
    logic [7:0] ram [NE];
    int wr_count = 0;
    int done_count = 0;
    int first_addr = -1;
    always @(posedge clk) begin
        #1;
        if (we === 1'b1) begin
            if (wr_count == 0) first_addr = int'(waddr);
            if (int'(waddr) < NE) ram[waddr] = wdata;
            wr_count++;
        end
        if (done === 1'b1) done_count++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk);
        #2;
        rx_dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input bit good);
        logic [7:0] s;
        s = a + b + c + d;
        send(8'hA5); send(a); send(b); send(c); send(d);
        if (CHK) send(good ? s : s + 8'h01);
    endtask

    task automatic clear_mon();
        for (int i = 0; i < NE; i++) ram[i] = 8'h00;
        wr_count = 0; done_count = 0; first_addr = -1;
    endtask

    task automatic expect_ram(input string nm, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        chk({nm, "_ram0"}, 32'(ram[0]), 32'(a));
        chk({nm, "_ram1"}, 32'(ram[1]), 32'(b));
        chk({nm, "_ram2"}, 32'(ram[2]), 32'(c));
        chk({nm, "_ram3"}, 32'(ram[3]), 32'(d));
        chk({nm, "_writes"}, 32'(wr_count), 32'(NE));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_error", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0;

        // basic load
        clear_mon();
        send(8'hA5);
        chk("basic_busy_after_hdr", 32'(busy), 32'd1);
        send(8'h10);
        chk("basic_first_we", 32'(we), 32'd1);
        chk("basic_first_addr", 32'(waddr), 32'd0);
        chk("basic_first_data", 32'(wdata), 32'h10);
        send(8'h20); send(8'h30); send(8'h40);
        if (CHK) send(8'hA0);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_end", 32'(busy), 32'd0);
        expect_ram("basic", 8'h10, 8'h20, 8'h30, 8'h40);
        @(posedge clk); #3;
        chk("basic_done_once", 32'(done_count), 32'd1);

        // garbage before header
        clear_mon();
        send(8'h00); send(8'hFF); send(8'h37);
        chk("garbage_no_write", 32'(wr_count), 32'd0);
        chk("garbage_idle", 32'(busy), 32'd0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        expect_ram("garbage", 8'h01, 8'h02, 8'h03, 8'h04);

        // sync byte inside payload
        clear_mon();
        send_frame(8'hA5, 8'hA5, 8'h00, 8'h01, 1'b1);
        chk("sync_done", 32'(done), 32'd1);
        expect_ram("sync", 8'hA5, 8'hA5, 8'h00, 8'h01);

        // timeout: error lands on the 16th quiet edge after the last byte
        clear_mon();
        send(8'hA5); send(8'h11);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("timeout_not_yet", 32'(err), 32'd0);
        chk("timeout_busy_pre", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("timeout_error", 32'(err), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_no_done", 32'(done_count), 32'd0);
        send(8'hA5);
        chk("timeout_err_cleared", 32'(err), 32'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        if (CHK) send(8'h0A);

        // bad checksum
        if (CHK) begin
            clear_mon();
            send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
            chk("cksum_bad_error", 32'(err), 32'd1);
            chk("cksum_bad_done", 32'(done_count), 32'd0);
            expect_ram("cksum_bad", 8'h01, 8'h02, 8'h03, 8'h04);
        end

        // reset mid-load
        send(8'hA5); send(8'hAA); send(8'hBB);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(waddr), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        @(negedge clk); rst = 1'b0;
        clear_mon();
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        chk("rst_first_addr", 32'(first_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd1);
        expect_ram("rst", 8'h01, 8'h02, 8'h03, 8'h04);

        // randomized frames, gaps, garbage, timeouts, resets
        for (int f = 0; f < 80; f++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) send(8'($urandom_range(0, 255)));
            end
            send(8'hA5);
            for (int k = 0; k < NE + (CHK ? 1 : 0); k++) begin
                int gap;
                gap = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 2))
                                                  : int'($urandom_range(0, 2));
                if (gap == TO - 1 || gap == TO) gap = TO - 1 + int'($urandom_range(0, 1));
                repeat (gap) @(negedge clk);
                if (kind == 1 && k == 2) begin
                    @(negedge clk); rst = 1'b1;
                    @(negedge clk); rst = 1'b0;
                end
                if ($urandom_range(0, 4) == 0) send(8'hA5);
                else                           send(8'($urandom_range(0, 255)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (TO + 4) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_ram_loader.md
# image_ram_loader

Write-side companion to the on-screen image block: accepts a framed byte stream from the UART receiver and writes one RGB332 image (`NumElements` bytes) into the image Block RAM's write port, starting at address 0. It sits between the UART RX and `BlockRam` (`i_write_en`/`i_write_addr`/`i_write_data`), so the sprite can be replaced at run time without resynthesis. Framing is a sync byte, the payload, and an optional checksum. An inter-byte timeout aborts stalled transfers.

## Interface
- `BusSize`, 11, width of the RAM write address.
- `NumElements`, 1600, payload bytes per image (40x40).
- `DataSize`, 8, RAM element width (RGB332).
- `SYNC_BYTE`, 8'hA5, frame header value.
- `TIMEOUT_CYCLES`, 2_500_000, maximum idle cycles between bytes inside a frame (100 ms at 25 MHz).
- `i_CLK` in 1: pixel clock, the only clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_dv` in 1: one-cycle strobe, `i_rx_byte` valid.
- `i_rx_byte` in 8: received byte.
- `o_write_en` out 1: RAM write strobe, one cycle per payload byte.
- `o_write_addr` out `BusSize`: RAM write address.
- `o_write_data` out `DataSize`: RAM write data.
- `o_busy` out 1: high from header acceptance until frame end or abort.
- `o_done` out 1: one-cycle pulse when a frame completes successfully.
- `o_error` out 1: sticky; set on timeout or checksum mismatch; cleared when the next header is accepted.

## Operation
- States are `IDLE`, `DATA`, and `CHECK`. `CHECK` exists only with `IMAGE_LOADER_CHECKSUM_EN`.
- **IDLE:**
  - A byte with `i_rx_dv` equal to `SYNC_BYTE` moves the block to `DATA`. It also clears the byte counter, the checksum and `o_error`, and sets `o_busy`.
  - All other bytes are ignored and produce no writes.
- **DATA:**
  - Each `i_rx_dv` issues one write: `o_write_addr` = counter, `o_write_data` = byte, `o_write_en` = 1 for one cycle.
  - The counter increments and the byte is added to the checksum. The checksum is an 8-bit sum mod 256; the header is excluded.
  - A byte equal to `SYNC_BYTE` is treated as payload, not as a restart.
  - On the byte where counter = `NumElements-1`:
    - Without the macro, go to `IDLE` and pulse `o_done`.
    - With the macro, go to `CHECK`.
- **CHECK:**
  - The next `i_rx_dv` byte is compared with the checksum.
  - Equal: pulse `o_done`.
  - Not equal: set `o_error`.
  - In both cases go to `IDLE` and clear `o_busy`.
- **Timeout:**
  - In `DATA` or `CHECK`, a counter counts cycles without `i_rx_dv` and resets to 0 on every `i_rx_dv`.
  - When it reaches `TIMEOUT_CYCLES-1` with no `i_rx_dv`, the block sets `o_error`, clears `o_busy` and goes to `IDLE`.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`.
- **Partial frames:** RAM contents already written stay in place. There is no rollback, and the display shows a partial image until the next good load.
- **Reset values:**
  - State is `IDLE`.
  - `o_write_en`, `o_write_addr`, `o_write_data`, `o_busy`, `o_done` and `o_error` are all 0.
  - The byte, checksum and timeout counters are 0.

## Timing
- **Write latency:** registered outputs; `o_write_en`, `o_write_addr` and `o_write_data` are valid the cycle after the accepting `i_rx_dv` edge. Address and data hold their last value while `o_write_en` = 0.
- **Completion:** `o_done` is high for exactly one cycle, in the cycle after the final payload byte (no macro) or after the checksum byte (macro). `o_busy` falls in the same cycle.
- **`o_error`:** rises in the cycle after the terminating event and stays high until the next accepted header.
- **Simultaneous events:**
  - If `i_rx_dv` and timeout expiry coincide, `i_rx_dv` wins: the byte is accepted and the counter reloads.
  - `i_reset` overrides everything, including a pending write or `o_done`.
- **Throughput:** one byte per cycle is sustainable; there is no back-pressure.
- **Wrap-around:** the counter never exceeds `NumElements-1`, so the address never wraps.

## Configuration
- Macro: `IMAGE_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The `CHECK` state exists and frames are `SYNC_BYTE` + `NumElements` bytes + 1 checksum byte.
  - A mismatch sets `o_error` and suppresses `o_done`.
  - RAM writes still occur before the checksum is known.
- **Undefined:**
  - Frames are `SYNC_BYTE` + `NumElements` bytes.
  - `o_done` follows the last payload byte.
  - `o_error` is set only by timeout.

## Test plan
- **Basic load** (`NumElements`=4, no macro): feed A5,10,20,30,40.
  - Writes addr 0..3 with data 10,20,30,40.
  - `o_done` pulses once, one cycle after the 40 strobe.
  - `o_busy` is 1 from after A5 until the `o_done` cycle.
- **Pre-header garbage:** feed 00,FF,37 then A5,01,02,03,04.
  - No `o_write_en` before A5.
  - Writes addr 0..3 with 01..04.
- **In-payload sync byte:** feed A5,A5,A5,00,01.
  - Writes addr0=A5, addr1=A5, addr2=00, addr3=01.
  - `o_done` pulses.
- **Timeout** (`TIMEOUT_CYCLES`=16): feed A5,11, then no strobe.
  - `o_error` = 1 and `o_busy` = 0 at the 16th idle cycle after the 11 strobe; no `o_done`.
  - A following A5 clears `o_error`.
- **Checksum** (macro defined):
  - A5,01,02,03,04,0A: `o_done` = 1, `o_error` = 0.
  - A5,01,02,03,04,0B: `o_error` = 1, no `o_done`, and the four writes still occurred.
- **Reset mid-load:** assert `i_reset` after A5,AA,BB for one cycle.
  - All outputs are 0 the next cycle.
  - A5,01,02,03,04 then writes starting at addr 0 and pulses `o_done`.
